apb_frame_decoder: RTL and testbench

- Parametrised successor to the first-generation RAH packet decoder. Reads RAH frames from the APB-side FIFO, parses the header frame and tracks how many bytes remain in the packet.
- Emits one annotated beat per frame on a valid/ready stream towards the APB master FSM.
- Adds generic widths, byte-accurate length accounting, last-beat marking and true backpressure, in place of the old hold flag.

---
 rtl/apb_rah_pkg.sv | 23 ++
 rtl/apb_skid_buf2.sv | 49 ++++
 rtl/apb_frame_decoder.sv | 136 +++++++++++++
 tb/tb_apb_frame_decoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_rah_pkg.sv
// Shared definitions for the RAH frame decoder: header field offsets, header
// payload size and the decoder state encoding.
package apb_rah_pkg;

    // Field offsets are counted down from the frame MSB so they hold for any frame width.
    localparam int CFG_BIT    = 0;
    localparam int SLV_ID_MSB = 1;
    localparam int HDR_BYTES  = 4;

    typedef enum logic {
        HDR  = 1'b0,
        DATA = 1'b1
    } state_t;

    function automatic int rw_bit(input int slv_id_width);
        return SLV_ID_MSB + slv_id_width;
    endfunction

    function automatic int len_msb(input int slv_id_width);
        return rw_bit(slv_id_width) + 1;
    endfunction

endpackage

// File: rtl/apb_skid_buf2.sv
// Two-entry register FIFO; entry 0 is always the head and is visible combinationally.
module apb_skid_buf2 #(
    parameter int WIDTH = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;

    assign head = mem0;

    // The writer never pushes into a full buffer without a pop in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= 2'd0;
        end else begin
            case ({wr_en, pop})
                2'b10: begin
                    if (count == 2'd0) mem0 <= wr_data;
                    else               mem1 <= wr_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        mem0 <= wr_data;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= wr_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/apb_frame_decoder.sv
// Parses RAH header frames from the APB-side FIFO and emits one annotated beat
// per frame with byte counts and last-beat marking on a valid/ready stream.
module apb_frame_decoder #(
    parameter int PACKET_WIDTH = 48,
    parameter int SLV_ID_WIDTH = 7,
    parameter int LENGTH_WIDTH = 7,
    parameter int HDR_BYTES    = apb_rah_pkg::HDR_BYTES,
    parameter int FRAME_BYTES  = PACKET_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    f_empty,
    output logic                    rd_en,
    input  logic [PACKET_WIDTH-1:0] f_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic                    o_hdr,
    output logic                    o_last,
    output logic                    o_cfg_sel,
    output logic [SLV_ID_WIDTH-1:0] o_slv_id,
    output logic                    o_rw,
    output logic [LENGTH_WIDTH-1:0] o_length,
    output logic [PACKET_WIDTH-1:0] o_data,
    output logic [LENGTH_WIDTH-1:0] o_bytes,
    output logic                    o_busy
);
    import apb_rah_pkg::*;

    localparam int LW1     = LENGTH_WIDTH + 1;
    localparam int CFG_POS = PACKET_WIDTH - 1 - CFG_BIT;
    localparam int SLV_POS = PACKET_WIDTH - 1 - SLV_ID_MSB;
    localparam int RW_POS  = PACKET_WIDTH - 1 - rw_bit(SLV_ID_WIDTH);
    localparam int LEN_POS = PACKET_WIDTH - 1 - len_msb(SLV_ID_WIDTH);

    state_t                  state;
    logic [LENGTH_WIDTH-1:0] rem;
    logic                    inflight;
    logic [1:0]              buf_cnt;
    logic [PACKET_WIDTH-1:0] head;
    logic                    lat_cfg;
    logic                    lat_rw;
    logic [SLV_ID_WIDTH-1:0] lat_slv;
    logic [LENGTH_WIDTH-1:0] lat_len;
    logic                    h_cfg;
    logic                    h_rw;
    logic [SLV_ID_WIDTH-1:0] h_slv;
    logic [LENGTH_WIDTH-1:0] h_len;
    logic                    xfer;
    logic                    last_c;
    logic [LENGTH_WIDTH-1:0] bytes_c;

    apb_skid_buf2 #(.WIDTH(PACKET_WIDTH)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (inflight),
        .wr_data (f_data),
        .pop     (xfer),
        .head    (head),
        .count   (buf_cnt)
    );

    assign h_cfg = head[CFG_POS];
    assign h_slv = head[SLV_POS -: SLV_ID_WIDTH];
    assign h_rw  = head[RW_POS];
    assign h_len = head[LEN_POS -: LENGTH_WIDTH];

    // Reads stop once buffered plus in-flight frames could fill both entries.
    assign rd_en   = rst_n && !f_empty && (({1'b0, buf_cnt} + {2'b00, inflight}) < 3'd2);
    assign o_valid = (buf_cnt != 2'd0);
    assign xfer    = o_valid && o_ready;

    // Comparisons at LENGTH_WIDTH+1 bits so large constants never wrap.
    always_comb begin
        bytes_c = '0;
        last_c  = 1'b0;
        if (state == HDR) begin
            if ({1'b0, h_len} <= LW1'(HDR_BYTES)) begin
                bytes_c = h_len;
                last_c  = 1'b1;
            end else begin
                bytes_c = LENGTH_WIDTH'(HDR_BYTES);
            end
        end else begin
            if ({1'b0, rem} <= LW1'(FRAME_BYTES)) begin
                bytes_c = rem;
                last_c  = 1'b1;
            end else begin
                bytes_c = LENGTH_WIDTH'(FRAME_BYTES);
            end
        end
    end

    assign o_hdr     = o_valid && (state == HDR);
    assign o_last    = o_valid && last_c;
    assign o_bytes   = o_valid ? bytes_c : '0;
    assign o_data    = head;
    assign o_cfg_sel = (state == HDR) ? h_cfg : lat_cfg;
    assign o_slv_id  = (state == HDR) ? h_slv : lat_slv;
    assign o_rw      = (state == HDR) ? h_rw  : lat_rw;
    assign o_length  = (state == HDR) ? h_len : lat_len;
    assign o_busy    = (state == DATA) || (buf_cnt != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HDR;
            rem      <= '0;
            inflight <= 1'b0;
            lat_cfg  <= 1'b0;
            lat_rw   <= 1'b0;
            lat_slv  <= '0;
            lat_len  <= '0;
        end else begin
            inflight <= rd_en;
            if (xfer) begin
                case (state)
                    HDR: begin
                        lat_cfg <= h_cfg;
                        lat_rw  <= h_rw;
                        lat_slv <= h_slv;
                        lat_len <= h_len;
                        if (!last_c) begin
                            rem   <= h_len - LENGTH_WIDTH'(HDR_BYTES);
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        rem <= rem - bytes_c;
                        if (last_c) state <= HDR;
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apb_frame_decoder.sv
// Directed bench for apb_frame_decoder: FIFO model, beat scoreboard and
// hand-computed byte/last sequences for each packet scenario.
module tb_apb_frame_decoder;

    localparam int PW = 48;
    localparam int SW = 7;
    localparam int LW = 7;

    typedef struct {
        logic [PW-1:0] data;
        logic          hdr;
        logic          last;
        logic          cfg;
        logic          rw;
        logic [SW-1:0] slv;
        logic [LW-1:0] len;
        logic [LW-1:0] bytes;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          f_empty = 1'b1;
    logic          rd_en;
    logic [PW-1:0] f_data = '0;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic          o_hdr;
    logic          o_last;
    logic          o_cfg_sel;
    logic [SW-1:0] o_slv_id;
    logic          o_rw;
    logic [LW-1:0] o_length;
    logic [PW-1:0] o_data;
    logic [LW-1:0] o_bytes;
    logic          o_busy;

    int            n_checks = 0;
    int            n_fail = 0;
    beat_t         exp_q[$];
    logic [PW-1:0] fifo_q[$];
    logic [LW-1:0] obs_bytes[$];
    logic          obs_last[$];
    logic          obs_busy[$];
    logic          starve = 1'b0;
    logic          block = 1'b0;
    logic          rd_seen;

    apb_frame_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_empty   (f_empty),
        .rd_en     (rd_en),
        .f_data    (f_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_hdr     (o_hdr),
        .o_last    (o_last),
        .o_cfg_sel (o_cfg_sel),
        .o_slv_id  (o_slv_id),
        .o_rw      (o_rw),
        .o_length  (o_length),
        .o_data    (o_data),
        .o_bytes   (o_bytes),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // FIFO model: data appears on f_data the cycle after rd_en.
    always @(posedge clk) begin
        rd_seen = rd_en;
        if (f_empty) check("rd_while_empty", {63'd0, rd_seen}, 64'd0);
        #1;
        if (rd_seen && fifo_q.size() > 0) f_data = fifo_q.pop_front();
        block   = starve ? ~block : 1'b0;
        f_empty = (fifo_q.size() == 0) || block;
    end

    // Scoreboard: every visible beat must match the expected head, stalled or not.
    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'd1, 64'd0);
            end else begin
                check("data",  o_data,    exp_q[0].data);
                check("hdr",   o_hdr,     exp_q[0].hdr);
                check("last",  o_last,    exp_q[0].last);
                check("bytes", o_bytes,   exp_q[0].bytes);
                check("cfg",   o_cfg_sel, exp_q[0].cfg);
                check("slv",   o_slv_id,  exp_q[0].slv);
                check("rw",    o_rw,      exp_q[0].rw);
                check("len",   o_length,  exp_q[0].len);
                if (o_ready) begin
                    void'(exp_q.pop_front());
                    obs_bytes.push_back(o_bytes);
                    obs_last.push_back(o_last);
                    obs_busy.push_back(o_busy);
                end
            end
        end
    end

    task automatic push_packet(input logic cfg, input logic [SW-1:0] slv, input logic rw,
                               input logic [LW-1:0] len, input logic [31:0] payload,
                               input logic [7:0] tag);
        beat_t         b;
        logic [LW-1:0] left;
        logic [PW-1:0] fr;
        int            i;
        fr = {cfg, slv, rw, len, payload};
        b.data = fr; b.hdr = 1'b1; b.cfg = cfg; b.slv = slv; b.rw = rw; b.len = len;
        if (len <= 7'd4) begin
            b.bytes = len; b.last = 1'b1; left = '0;
        end else begin
            b.bytes = 7'd4; b.last = 1'b0; left = len - 7'd4;
        end
        fifo_q.push_back(fr);
        exp_q.push_back(b);
        i = 0;
        while (left > 0) begin
            fr = {tag, 8'(i), 32'hC0DE0000 + 32'(i)};
            b.data = fr; b.hdr = 1'b0;
            if (left <= 7'd6) begin
                b.bytes = left; b.last = 1'b1; left = '0;
            end else begin
                b.bytes = 7'd6; b.last = 1'b0; left = left - 7'd6;
            end
            fifo_q.push_back(fr);
            exp_q.push_back(b);
            i++;
        end
    endtask

    task automatic clear_obs();
        obs_bytes.delete();
        obs_last.delete();
        obs_busy.delete();
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            check({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_beats(input int cnt, input int budget, input string tag);
        int n = 0;
        while (obs_bytes.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (obs_bytes.size() < cnt) check({tag, "_timeout"}, 64'(obs_bytes.size()), 64'(cnt));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, o_valid,  0);
        check({tag, "_hdr"},   o_hdr,    0);
        check({tag, "_last"},  o_last,   0);
        check({tag, "_bytes"}, o_bytes,  0);
        check({tag, "_data"},  o_data,   0);
        check({tag, "_slv"},   o_slv_id, 0);
        check({tag, "_len"},   o_length, 0);
        check({tag, "_busy"},  o_busy,   0);
        check({tag, "_rd_en"}, rd_en,    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with a frame already waiting so rd_en gating is exercised.
        repeat (2) @(posedge clk);
        push_packet(1'b1, 7'h05, 1'b1, 7'd4, 32'hDEADBEEF, 8'hA1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_fifo_nonempty_seen", f_empty, 0);
        check_zero_outputs("reset");

        // Test 1: single header-only packet.
        @(posedge clk); #1;
        rst_n = 1'b1;
        o_ready = 1'b1;
        clear_obs();
        wait_drain(50, "t1");
        @(negedge clk);
        check("t1_n_beats", 64'(obs_bytes.size()), 1);
        check("t1_bytes", obs_bytes[0], 4);
        check("t1_last", obs_last[0], 1);
        check("t1_busy_after", o_busy, 0);

        // Test 2: length 16 -> 4, 6, 6.
        clear_obs();
        push_packet(1'b0, 7'h22, 1'b0, 7'd16, 32'h12345678, 8'hB2);
        wait_drain(50, "t2");
        @(negedge clk);
        check("t2_n_beats", 64'(obs_bytes.size()), 3);
        check("t2_bytes0", obs_bytes[0], 4);
        check("t2_bytes1", obs_bytes[1], 6);
        check("t2_bytes2", obs_bytes[2], 6);
        check("t2_last0", obs_last[0], 0);
        check("t2_last1", obs_last[1], 0);
        check("t2_last2", obs_last[2], 1);

        // Test 3: maximum length 127 -> 22 beats, last carries 3 bytes.
        clear_obs();
        push_packet(1'b1, 7'h7F, 1'b0, 7'd127, 32'hCAFEF00D, 8'hC3);
        wait_drain(200, "t3");
        @(negedge clk);
        check("t3_n_beats", 64'(obs_bytes.size()), 22);
        check("t3_bytes_last", obs_bytes[21], 3);
        check("t3_last_last", obs_last[21], 1);
        check("t3_last_prev", obs_last[20], 0);
        check("t3_busy_on_last", obs_busy[21], 1);
        check("t3_busy_after", o_busy, 0);

        // Test 4: 5-cycle backpressure mid-packet.
        clear_obs();
        push_packet(1'b0, 7'h11, 1'b1, 7'd40, 32'h0BADBEEF, 8'hD4);
        wait_beats(2, 50, "t4_start");
        @(posedge clk); #1;
        o_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t4_rd_en_full", rd_en, 0);
        check("t4_valid_stall", o_valid, 1);
        @(posedge clk); #1;
        o_ready = 1'b1;
        wait_drain(100, "t4");
        @(negedge clk);
        check("t4_n_beats", 64'(obs_bytes.size()), 7);

        // Test 5: FIFO starvation, f_empty toggling every cycle.
        clear_obs();
        starve = 1'b1;
        push_packet(1'b1, 7'h2A, 1'b0, 7'd40, 32'h55AA55AA, 8'hE5);
        wait_drain(200, "t5");
        starve = 1'b0;
        @(negedge clk);
        check("t5_n_beats", 64'(obs_bytes.size()), 7);
        check("t5_bytes0", obs_bytes[0], 4);
        for (int k = 1; k < 7; k++) check("t5_bytes_data", obs_bytes[k], 6);
        check("t5_last_mid", obs_last[5], 0);
        check("t5_last_end", obs_last[6], 1);

        // Test 6: reset during the second data frame of a length-30 packet.
        clear_obs();
        push_packet(1'b0, 7'h44, 1'b1, 7'd30, 32'h87654321, 8'hF6);
        wait_beats(2, 50, "t6_start");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t6_reset");
        exp_q.delete();
        fifo_q.delete();
        clear_obs();
        push_packet(1'b1, 7'h33, 1'b0, 7'd2, 32'h0000BEEF, 8'h07);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_drain(50, "t6");
        @(negedge clk);
        check("t6_n_beats", 64'(obs_bytes.size()), 1);
        check("t6_bytes", obs_bytes[0], 2);
        check("t6_last", obs_last[0], 1);
        check("t6_busy_after", o_busy, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
